// File: rtl/reg_bank_sc.sv
// Multi-channel double-buffered register bank: byte-masked RMW writes into a
// shadow register per channel, copied to the live register on a commit strobe.

module reg_bank_sc_ch #(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr,
  input  logic [2:0]           mode,
  input  logic [WIDTH-1:0]     d,
  input  logic [WIDTH/8-1:0]   be,
  input  logic                 commit,
  output logic [WIDTH-1:0]     shadow,
  output logic [WIDTH-1:0]     live,
  output logic                 dirty
);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] r_shadow, r_live;
  logic             r_dirty;
  logic [WIDTH-1:0] w_r, w_next;

  always_comb begin
    w_r = r_shadow;
    case (mode)
      3'b000: w_r = d;
      3'b001: w_r = r_shadow | d;
      3'b010: w_r = r_shadow & ~d;
      3'b011: w_r = r_shadow ^ d;
      3'b100: w_r = r_shadow + d;
      3'b101: w_r = {r_shadow[WIDTH-2:0], d[0]};
      3'b110: w_r = {d[WIDTH-1], r_shadow[WIDTH-1:1]};
      default: w_r = r_shadow;
    endcase
  end

  // Merge after the full-width op so add carries cross masked-off bytes.
  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign w_next[8*b +: 8] = (wr && be[b]) ? w_r[8*b +: 8] : r_shadow[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= RESET_VAL;
      r_live   <= RESET_VAL;
      r_dirty  <= 1'b0;
    end else begin
      r_shadow <= w_next;
      if (commit) r_live <= w_next;
      if (commit)  r_dirty <= 1'b0;
      else if (wr) r_dirty <= 1'b1;
    end
  end

  assign shadow = r_shadow;
  assign live   = r_live;
  assign dirty  = r_dirty;
endmodule

module reg_bank_sc #(
  parameter int                WIDTH     = 32,
  parameter int                CHANNELS  = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int               SW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic [SW-1:0]               sel,
  input  logic [2:0]                  mode,
  input  logic [WIDTH-1:0]            d,
  input  logic [WIDTH/8-1:0]          be,
  input  logic [CHANNELS-1:0]         commit,
  output logic [CHANNELS*WIDTH-1:0]   q,
  output logic [CHANNELS-1:0]         dirty,
  input  logic [SW-1:0]               rsel,
  output logic [WIDTH-1:0]            rdata
);
  localparam int NSEL = 1 << SW;

  logic [CHANNELS-1:0]             w_wr;
  logic [CHANNELS-1:0][WIDTH-1:0]  w_shadow, w_live;
  logic [NSEL-1:0][WIDTH-1:0]      w_rd;

  // Out-of-range sel matches no channel, so the write is dropped.
  always_comb begin
    w_wr = '0;
    for (int k = 0; k < CHANNELS; k++) w_wr[k] = ce && (sel == SW'(k));
  end

  reg_bank_sc_ch #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_ch [CHANNELS-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr     (w_wr),
    .mode   (mode),
    .d      (d),
    .be     (be),
    .commit (commit),
    .shadow (w_shadow),
    .live   (w_live),
    .dirty  (dirty)
  );

  for (genvar i = 0; i < NSEL; i++) begin : g_rd
    if (i < CHANNELS) begin : g_valid
      assign w_rd[i] = w_shadow[i];
    end else begin : g_zero
      assign w_rd[i] = '0;
    end
  end

  assign rdata = w_rd[rsel];
  assign q     = w_live;
endmodule

// File: tb/tb_reg_bank_sc.sv
// Self-checking bench for reg_bank_sc: directed vector table, corner sequences,
// and randomized traffic against a behavioural model.

module tb_reg_bank_sc;
  localparam logic [31:0] RV = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         ce;
  logic [1:0]   sel, rsel;
  logic [2:0]   mode;
  logic [31:0]  d, rdata;
  logic [3:0]   be, commit, dirty;
  logic [127:0] q;

  logic         b_ce;
  logic [1:0]   b_sel, b_rsel;
  logic [2:0]   b_mode;
  logic [31:0]  b_d, b_rdata;
  logic [3:0]   b_be;
  logic [2:0]   b_commit, b_dirty;
  logic [95:0]  b_q;

  reg_bank_sc #(.WIDTH(32), .CHANNELS(4), .RESET_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .sel(sel), .mode(mode), .d(d), .be(be),
    .commit(commit), .q(q), .dirty(dirty), .rsel(rsel), .rdata(rdata));

  reg_bank_sc #(.WIDTH(32), .CHANNELS(3), .RESET_VAL(RV)) dut3 (
    .clk(clk), .rst_n(rst_n), .ce(b_ce), .sel(b_sel), .mode(b_mode), .d(b_d), .be(b_be),
    .commit(b_commit), .q(b_q), .dirty(b_dirty), .rsel(b_rsel), .rdata(b_rdata));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ce;
    logic [1:0]  sel;
    logic [2:0]  mode;
    logic [31:0] d;
    logic [3:0]  be;
    logic [3:0]  commit;
    logic [1:0]  rsel;
    logic [31:0] e_rd;
    int          qch;
    logic [31:0] e_q;
    logic [3:0]  e_dirty;
  } vec_t;

  vec_t tv[16];

  // Behavioural model state
  logic [31:0] m_sh[4], m_lv[4];
  logic [3:0]  m_dt;

  function automatic logic [31:0] op(input logic [2:0] m, input logic [31:0] o, input logic [31:0] x);
    case (m)
      3'd0: return x;
      3'd1: return o | x;
      3'd2: return o & ~x;
      3'd3: return o ^ x;
      3'd4: return o + x;
      3'd5: return (o << 1) | {31'b0, x[0]};
      3'd6: return (o >> 1) | {x[31], 31'b0};
      default: return o;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] nsh[4];
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      nsh[k] = m_sh[k];
      if (ce && sel == 2'(k)) begin
        r = op(mode, m_sh[k], d);
        for (int b = 0; b < 4; b++) if (be[b]) nsh[k][8*b +: 8] = r[8*b +: 8];
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (commit[k]) begin
        m_lv[k] = nsh[k];
        m_dt[k] = 1'b0;
      end else if (ce && sel == 2'(k)) m_dt[k] = 1'b1;
      m_sh[k] = nsh[k];
    end
  endtask

  initial begin
    rst_n = 1'b1; ce = 1'b0; sel = '0; rsel = '0; mode = '0; d = '0; be = '0; commit = '0;
    b_ce = 1'b0; b_sel = '0; b_rsel = '0; b_mode = '0; b_d = '0; b_be = '0; b_commit = '0;

    tv[0]  = '{1'b1, 2'd2, 3'd0, 32'h1234_5678, 4'hF, 4'b0000, 2'd2, 32'h1234_5678, 2, RV,           4'b0100};
    tv[1]  = '{1'b0, 2'd0, 3'd0, 32'h0,         4'h0, 4'b0100, 2'd2, 32'h1234_5678, 2, 32'h1234_5678, 4'b0000};
    tv[2]  = '{1'b1, 2'd0, 3'd0, 32'h0000_00FF, 4'hF, 4'b0000, 2'd0, 32'h0000_00FF, 0, RV,           4'b0001};
    tv[3]  = '{1'b1, 2'd0, 3'd1, 32'hFF00_0000, 4'h8, 4'b0000, 2'd0, 32'hFF00_00FF, 0, RV,           4'b0001};
    tv[4]  = '{1'b1, 2'd0, 3'd2, 32'h0000_000F, 4'h1, 4'b0000, 2'd0, 32'hFF00_00F0, 0, RV,           4'b0001};
    tv[5]  = '{1'b1, 2'd0, 3'd3, 32'hFFFF_FFFF, 4'h6, 4'b0000, 2'd0, 32'hFFFF_FFF0, 0, RV,           4'b0001};
    tv[6]  = '{1'b1, 2'd0, 3'd0, 32'hFFFF_FFFF, 4'hF, 4'b0000, 2'd0, 32'hFFFF_FFFF, 0, RV,           4'b0001};
    tv[7]  = '{1'b1, 2'd0, 3'd4, 32'h0000_0001, 4'hF, 4'b0000, 2'd0, 32'h0000_0000, 0, RV,           4'b0001};
    tv[8]  = '{1'b1, 2'd0, 3'd0, 32'h8000_0000, 4'hF, 4'b0000, 2'd0, 32'h8000_0000, 0, RV,           4'b0001};
    tv[9]  = '{1'b1, 2'd0, 3'd5, 32'h0000_0001, 4'hF, 4'b0000, 2'd0, 32'h0000_0001, 0, RV,           4'b0001};
    tv[10] = '{1'b1, 2'd0, 3'd6, 32'h8000_0000, 4'hF, 4'b0000, 2'd0, 32'h8000_0000, 0, RV,           4'b0001};
    tv[11] = '{1'b1, 2'd0, 3'd7, 32'h1234_5678, 4'hF, 4'b0000, 2'd0, 32'h8000_0000, 0, RV,           4'b0001};
    tv[12] = '{1'b1, 2'd1, 3'd0, 32'hDEAD_BEEF, 4'hF, 4'b0011, 2'd1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 4'b0000};
    tv[13] = '{1'b0, 2'd0, 3'd0, 32'h0,         4'h0, 4'b0000, 2'd0, 32'h8000_0000, 0, 32'h8000_0000, 4'b0000};
    tv[14] = '{1'b1, 2'd3, 3'd0, 32'h0,         4'h0, 4'b0000, 2'd3, RV,            3, RV,           4'b1000};
    tv[15] = '{1'b0, 2'd0, 3'd0, 32'h0,         4'h0, 4'b1000, 2'd3, RV,            3, RV,           4'b0000};

    // Async reset between edges, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("reset_q", q, {4{RV}});
    chk("reset_dirty", {124'b0, dirty}, 128'd0);
    chk("reset_rdata", {96'b0, rdata}, {96'b0, RV});
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      ce = tv[i].ce; sel = tv[i].sel; mode = tv[i].mode; d = tv[i].d;
      be = tv[i].be; commit = tv[i].commit; rsel = tv[i].rsel;
      step();
      chk($sformatf("v%0d_rdata", i), {96'b0, rdata}, {96'b0, tv[i].e_rd});
      chk($sformatf("v%0d_q", i), {96'b0, q[tv[i].qch*32 +: 32]}, {96'b0, tv[i].e_q});
      chk($sformatf("v%0d_dirty", i), {124'b0, dirty}, {124'b0, tv[i].e_dirty});
    end

    // Reset mid-operation discards staged data
    ce = 1'b1; sel = 2'd0; mode = 3'd0; d = 32'h55; be = 4'hF; commit = '0; rsel = 2'd0;
    step();
    ce = 1'b0;
    chk("mid_stage", {96'b0, rdata}, {96'b0, 32'h55});
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rdata", {96'b0, rdata}, {96'b0, RV});
    chk("mid_dirty", {124'b0, dirty}, 128'd0);
    #1 rst_n = 1'b1;
    commit = 4'b0001;
    step();
    commit = '0;
    chk("mid_commit_q0", {96'b0, q[31:0]}, {96'b0, RV});

    // Out-of-range select on the 3-channel instance
    b_ce = 1'b1; b_sel = 2'd1; b_mode = 3'd0; b_d = 32'h1111_1111; b_be = 4'hF;
    step();
    b_sel = 2'd3; b_d = 32'hFFFF_FFFF;
    step();
    b_ce = 1'b0;
    chk("inv_dirty", {125'b0, b_dirty}, {125'b0, 3'b010});
    b_rsel = 2'd0; #1 chk("inv_rd0", {96'b0, b_rdata}, {96'b0, RV});
    b_rsel = 2'd1; #1 chk("inv_rd1", {96'b0, b_rdata}, {96'b0, 32'h1111_1111});
    b_rsel = 2'd2; #1 chk("inv_rd2", {96'b0, b_rdata}, {96'b0, RV});
    b_rsel = 2'd3; #1 chk("inv_rd3", {96'b0, b_rdata}, 128'd0);
    chk("inv_q", {32'b0, b_q}, {32'b0, {3{RV}}});

    // Randomized traffic against the model, from a fresh reset
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_sh[k] = RV;
      m_lv[k] = RV;
    end
    m_dt = '0;
    for (int n = 0; n < 300; n++) begin
      ce = 1'($urandom_range(0, 3) != 0);
      sel = 2'($urandom);
      mode = 3'($urandom);
      d = $urandom;
      be = 4'($urandom);
      commit = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      rsel = 2'($urandom);
      model_edge();
      step();
      chk($sformatf("rnd%0d_q", n), q, {m_lv[3], m_lv[2], m_lv[1], m_lv[0]});
      chk($sformatf("rnd%0d_dirty", n), {124'b0, dirty}, {124'b0, m_dt});
      chk($sformatf("rnd%0d_rdata", n), {96'b0, rdata}, {96'b0, m_sh[rsel]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_bank_sc.md
# reg_bank_sc

Parametrised, multi-channel, double-buffered register bank for the MDP datapath. It is the successor to the plain 32-bit clock-enabled register. Each channel has a shadow (staging) register, written with byte enables and one of eight read-modify-write modes, and a live register that only updates on a per-channel commit strobe. Peripherals can stage several fields and apply them atomically on the same clock edge.

## Interface
Parameters:
- WIDTH, 32: bits per channel; must be a multiple of 8.
- CHANNELS, 4: number of channels, 1..16.
- RESET_VAL, 0: value of every shadow and live register after reset.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ce  in  1  shadow write enable.
- sel  in  SW  channel written when ce=1; SW = max(1, clog2(CHANNELS)).
- mode  in  3  write mode (see Operation).
- d  in  WIDTH  write operand.
- be  in  WIDTH/8  byte enables; be[i] covers d[8i+7:8i].
- commit  in  CHANNELS  per-channel shadow-to-live copy strobe.
- q  out  CHANNELS*WIDTH  live registers, flattened; channel k at q[k*WIDTH +: WIDTH].
- dirty  out  CHANNELS  channel k has shadow writes not yet committed.
- rsel  in  SW  readback channel select.
- rdata  out  WIDTH  shadow[rsel], combinational.

## Operation
- Reset (rst_n=0, regardless of clk): every shadow and live register = RESET_VAL; dirty = 0; q and rdata reflect this immediately.
- Shadow write occurs when ce=1 and sel<CHANNELS. If sel>=CHANNELS, the write is ignored: no state change, dirty unchanged.
- Let old = shadow[sel]. The full-width result r is computed by mode:
  - 000 load: r = d.
  - 001 set: r = old | d.
  - 010 clear: r = old & ~d.
  - 011 toggle: r = old ^ d.
  - 100 add: r = (old + d) mod 2^WIDTH. Carries propagate across all bytes before masking.
  - 101 shift-left: r = {old[WIDTH-2:0], d[0]}.
  - 110 shift-right: r = {d[WIDTH-1], old[WIDTH-1:1]}.
  - 111 hold: r = old. This counts as a write for the dirty flag.
- Byte merge: new shadow byte i = be[i] ? r byte i : old byte i.
  - be=0 with ce=1 leaves the shadow unchanged but still sets dirty[sel].
- Commit: for each k with commit[k]=1, live[k] takes the shadow[k] value that results after this edge's write. A write and commit to the same channel on the same edge passes the new value straight through to live in one edge.
- dirty[k] next-state rules:
  - cleared if commit[k]=1;
  - else set if a valid write targets k;
  - else held.
  - A simultaneous write and commit leaves dirty[k]=0.
- Multiple commit bits may be set at once; all selected channels update on the same edge (atomic group apply).
- The live register is never written directly. q changes only via commit or reset.
- rdata for rsel>=CHANNELS is 0.

## Timing
- Shadow write latency is 1 edge; rdata reflects it after that edge.
- Live update latency is 1 edge after commit is sampled. Worst case from ce to q is 1 edge (write and commit together).
- All inputs are sampled on the rising clk edge. There is no handshake and no backpressure; every cycle can accept a write.
- Reset asserted mid-sequence discards staged data and pending dirty bits.
- Release of rst_n is synchronised externally; the block makes no recovery guarantee for an edge coincident with release.
- rdata is the only combinational output path (rsel to rdata).

## Test plan
- Reset: CHANNELS=4, RESET_VAL=32'hA5A5_0000; pulse rst_n low between edges.
  - Expect all q channels = A5A50000, dirty=0 with no clock edge required.
- Staged write:
  - load ch2 with d=32'h1234_5678, be=4'hF → rdata(rsel=2)=12345678, q ch2 unchanged, dirty=4'b0100.
  - commit=4'b0100 → q ch2=12345678, dirty=0.
- Modes and byte enables on ch0 = 32'h0000_00FF:
  - set d=32'hFF00_0000, be=4'b1000 → FF0000FF;
  - clear d=32'h0000_000F, be=4'h1 → FF0000F0;
  - toggle d=32'hFFFF_FFFF, be=4'b0110 → FFFFFFF0;
  - add d=1, be=4'hF on FFFFFFFF → 00000000 (wrap);
  - shift-left d[0]=1 on 80000000 → 00000001.
- Simultaneous write and commit: load ch1 d=32'hDEAD_BEEF with commit=4'b0011 on the same edge.
  - q ch1=DEADBEEF after 1 edge; q ch0 = the prior shadow ch0; dirty=0.
- Invalid select: CHANNELS=3, sel=3, ce=1, d=32'hFFFF_FFFF.
  - No shadow changes, dirty unchanged; rdata(rsel=3)=0.
- Reset mid-operation: stage ch0 to 32'h55, leave uncommitted, assert rst_n=0.
  - Expect rdata(rsel=0)=RESET_VAL, dirty=0; a subsequent commit=4'b0001 leaves q ch0=RESET_VAL.
